// File: rtl/tx_rs_layer_if.sv
// ----------------------------------------------------------------------------
// tx_rs_layer_if -- MAC-to-XGMII transmit bus bundle for tx_rs_layer.
//
// Signals:
//   txd64      MAC data word, lane n = bits 8n+7:8n, lane 0 first on the wire
//   txc8       per-lane control flags for txd64
//   link_fault 00 OK, 01 local fault, 10 remote fault, 11 same as 01
//   tx_ack     high in the cycle whose closing edge samples txd64/txc8
//   txd_out    32-bit XGMII column, lane 0 = bits 7:0
//   txc_out    XGMII per-lane control flags
//   tx_mode    mode of the last sampled word (00 pass, 01 RF, 10 idle)
//   drop_cnt   saturating count of MAC words discarded in fault modes
//
// Modports: master = MAC / stimulus side, slave = tx_rs_layer.
// ----------------------------------------------------------------------------
interface tx_rs_layer_if #(
  parameter int DROP_CNT_W = 16
);
  logic [63:0]           txd64;
  logic [7:0]            txc8;
  logic [1:0]            link_fault;
  logic                  tx_ack;
  logic [31:0]           txd_out;
  logic [3:0]            txc_out;
  logic [1:0]            tx_mode;
  logic [DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output txd64, txc8, link_fault,
    input  tx_ack, txd_out, txc_out, tx_mode, drop_cnt
  );

  modport slave (
    input  txd64, txc8, link_fault,
    output tx_ack, txd_out, txc_out, tx_mode, drop_cnt
  );
endinterface

// File: rtl/tx_rs_layer.sv
// ----------------------------------------------------------------------------
// tx_rs_layer -- transmit reconciliation sublayer.
//
// Takes one 64-bit MAC word every two txclk_2x cycles and emits it as two
// 32-bit XGMII columns (low half first). Depending on link_fault the word is
// passed through, or replaced by Remote Fault or Idle columns; replaced words
// are counted in drop_cnt (saturating).
//
// Ports:
//   txclk_2x  sole clock, rising edge
//   reset     synchronous, active-high
//   bus       tx_rs_layer_if.slave (data in, ack, columns out, status)
//
// Configuration macro: TX_RS_FRAME_GUARD_EN
//   defined   - a frame in progress (Start seen, no Terminate yet) is always
//               forwarded; a fault takes effect after the Terminate word.
//   undefined - a fault takes effect at the next sampling edge and may cut a
//               frame short; any replaced word clears the in-frame flag.
// ----------------------------------------------------------------------------
module tx_rs_layer #(
  parameter int DROP_CNT_W = 16
) (
  input  logic           txclk_2x,
  input  logic           reset,
  tx_rs_layer_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_RF   = 2'b01,
    MODE_IDLE = 2'b10
  } mode_e;

  localparam logic [31:0] IDLE_D   = 32'h07070707;
  localparam logic [3:0]  IDLE_C   = 4'hF;
  localparam logic [31:0] RF_D     = 32'h0200009C;
  localparam logic [3:0]  RF_C     = 4'b0001;
  localparam logic [7:0]  CH_START = 8'hFB;
  localparam logic [7:0]  CH_TERM  = 8'hFD;

  localparam logic [DROP_CNT_W-1:0] DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

  logic                  phase;     // 0 = sampling cycle, 1 = high-half cycle
  logic                  in_frame;
  mode_e                 mode_q;
  logic [31:0]           txd_q;
  logic [3:0]            txc_q;
  logic [31:0]           hi_d_q;
  logic [3:0]            hi_c_q;
  logic [DROP_CNT_W-1:0] drop_q;

  mode_e                 fault_mode;
  mode_e                 eff_mode;
  logic [63:0]           sel_d;
  logic [7:0]            sel_c;
  logic                  in_frame_nxt;

  // Mode requested by the link state alone.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no branch can
    // leave it unassigned and infer a latch.
    fault_mode = MODE_RF;
    case (bus.link_fault)
      2'b00:   fault_mode = MODE_PASS;
      2'b10:   fault_mode = MODE_IDLE;
      default: fault_mode = MODE_RF;
    endcase
  end

`ifdef TX_RS_FRAME_GUARD_EN
  // A frame in progress is never cut: pass until the Terminate word is out.
  assign eff_mode = in_frame ? MODE_PASS : fault_mode;
`else
  assign eff_mode = fault_mode;
`endif

  // Word selection and frame tracking for the word being sampled.
  always_comb begin
    sel_d        = bus.txd64;
    sel_c        = bus.txc8;
    in_frame_nxt = in_frame;
    case (eff_mode)
      MODE_RF: begin
        sel_d = {RF_D, RF_D};
        sel_c = {RF_C, RF_C};
      end
      MODE_IDLE: begin
        sel_d = {IDLE_D, IDLE_D};
        sel_c = {IDLE_C, IDLE_C};
      end
      default: ;
    endcase

    if (eff_mode == MODE_PASS) begin
      // Scan in wire order so the last Start/Terminate in the word wins.
      for (int i = 0; i < 8; i++) begin
        if (bus.txc8[i] && bus.txd64[8*i +: 8] == CH_START) in_frame_nxt = 1'b1;
        if (bus.txc8[i] && bus.txd64[8*i +: 8] == CH_TERM)  in_frame_nxt = 1'b0;
      end
    end else begin
      // A discarded word never leaves a partial frame open.
      in_frame_nxt = 1'b0;
    end
  end

  always_ff @(posedge txclk_2x) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here sees the values from before this edge.
    if (reset) begin
      phase    <= 1'b0;
      in_frame <= 1'b0;
      mode_q   <= MODE_IDLE;
      txd_q    <= IDLE_D;
      txc_q    <= IDLE_C;
      drop_q   <= '0;
    end else begin
      phase <= ~phase;
      if (!phase) begin
        txd_q    <= sel_d[31:0];
        txc_q    <= sel_c[3:0];
        mode_q   <= eff_mode;
        in_frame <= in_frame_nxt;
        if (eff_mode != MODE_PASS && drop_q != DROP_MAX)
          drop_q <= drop_q + DROP_ONE;
      end else begin
        txd_q <= hi_d_q;
        txc_q <= hi_c_q;
      end
    end
  end

  // NOTE: the high-half holding register has no reset: phase is 0 after
  // reset, so it is always written at a sampling edge before it is driven.
  always_ff @(posedge txclk_2x) begin
    if (!phase) begin
      hi_d_q <= sel_d[63:32];
      hi_c_q <= sel_c[7:4];
    end
  end

  assign bus.tx_ack   = ~phase;
  assign bus.txd_out  = txd_q;
  assign bus.txc_out  = txc_q;
  assign bus.tx_mode  = mode_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_tx_rs_layer.sv
// ----------------------------------------------------------------------------
// tb_tx_rs_layer -- directed testbench for tx_rs_layer (DROP_CNT_W = 4).
// Inputs change and outputs are sampled on the falling edge of txclk_2x.
// Frame-guard expectations follow the TX_RS_FRAME_GUARD_EN macro.
// ----------------------------------------------------------------------------
module tb_tx_rs_layer;

  localparam int DW = 4;

`ifdef TX_RS_FRAME_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  localparam logic [1:0] M_PASS = 2'b00;
  localparam logic [1:0] M_RF   = 2'b01;
  localparam logic [1:0] M_IDLE = 2'b10;

  localparam logic [63:0] IDLE_WORD = 64'h07070707_07070707;

  logic txclk_2x = 1'b0;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;
  int exp_drop = 0;

  tx_rs_layer_if #(.DROP_CNT_W(DW)) bus ();

  tx_rs_layer #(.DROP_CNT_W(DW)) dut (
    .txclk_2x (txclk_2x),
    .reset    (reset),
    .bus      (bus.slave)
  );

  always #5 txclk_2x = ~txclk_2x;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Must be entered on a falling edge in a tx_ack cycle; returns on the
  // falling edge of the next tx_ack cycle.
  task automatic do_word(input string tag, input logic [63:0] d, input logic [7:0] c,
                         input logic [1:0] lf, input logic [1:0] m);
    logic [31:0] lo_d, hi_d;
    logic [3:0]  lo_c, hi_c;
    case (m)
      M_RF:   begin lo_d = 32'h0200009C; hi_d = 32'h0200009C; lo_c = 4'b0001; hi_c = 4'b0001; end
      M_IDLE: begin lo_d = 32'h07070707; hi_d = 32'h07070707; lo_c = 4'hF;    hi_c = 4'hF;    end
      default: begin lo_d = d[31:0]; hi_d = d[63:32]; lo_c = c[3:0]; hi_c = c[7:4]; end
    endcase
    if (m != M_PASS && exp_drop < (1 << DW) - 1) exp_drop++;

    check({tag, ".ack"}, bus.tx_ack, 1'b1);
    bus.txd64      = d;
    bus.txc8       = c;
    bus.link_fault = lf;
    @(negedge txclk_2x);
    check({tag, ".lo_d"}, bus.txd_out, lo_d);
    check({tag, ".lo_c"}, bus.txc_out, lo_c);
    check({tag, ".mode"}, bus.tx_mode, m);
    check({tag, ".drop"}, bus.drop_cnt, exp_drop[DW-1:0]);
    @(negedge txclk_2x);
    check({tag, ".hi_d"}, bus.txd_out, hi_d);
    check({tag, ".hi_c"}, bus.txc_out, hi_c);
  endtask

  initial begin
    bus.txd64      = IDLE_WORD;
    bus.txc8       = 8'hFF;
    bus.link_fault = 2'b00;
    reset          = 1'b1;
    repeat (3) @(posedge txclk_2x);
    @(negedge txclk_2x);
    reset = 1'b0;

    // Reset state, first post-reset cycle.
    check("rst.txd",  bus.txd_out,  32'h07070707);
    check("rst.txc",  bus.txc_out,  4'hF);
    check("rst.mode", bus.tx_mode,  M_IDLE);
    check("rst.drop", bus.drop_cnt, '0);
    check("rst.ack",  bus.tx_ack,   1'b1);

    // Plain pass-through.
    do_word("pass", 64'h0706050403020100, 8'h00, 2'b00, M_PASS);

    // Local fault with idle MAC input: four words of RF.
    for (int i = 0; i < 4; i++)
      do_word("rf", IDLE_WORD, 8'hFF, 2'b01, M_RF);
    check("rf.drop4", bus.drop_cnt, 4'd4);

    // Remote fault raised mid-frame.
    do_word("fr.start", 64'h55555555_555555FB, 8'h01, 2'b00, M_PASS);
    do_word("fr.data",  64'h11111111_11111111, 8'h00, 2'b10, GUARD ? M_PASS : M_IDLE);
    do_word("fr.term",  64'h07070707_FD222222, 8'hF8, 2'b10, GUARD ? M_PASS : M_IDLE);
    do_word("fr.after", 64'h33333333_33333333, 8'h00, 2'b10, M_IDLE);

    // Fault clears: pass at the next sampling edge.
    do_word("clr", 64'h89ABCDEF_01234567, 8'h00, 2'b00, M_PASS);

    // Terminate then Start in one word: Start wins, frame stays open.
    do_word("lw.ts",   64'h0707FB07_0707FD07, 8'hFF, 2'b00, M_PASS);
    do_word("lw.data", 64'h44444444_44444444, 8'h00, 2'b01, GUARD ? M_PASS : M_RF);
    // Start then Terminate in one word: Terminate wins, frame closes.
    do_word("lw.st",   64'h070707FD_070707FB, 8'hFF, 2'b01, GUARD ? M_PASS : M_RF);
    do_word("lw.rf",   64'h66666666_66666666, 8'h00, 2'b01, M_RF);

    // Reset asserted in phase 1 in the middle of a frame.
    check("mr.ack", bus.tx_ack, 1'b1);
    bus.txd64      = 64'h55555555_555555FB;
    bus.txc8       = 8'h01;
    bus.link_fault = 2'b00;
    @(negedge txclk_2x);
    check("mr.lo_d", bus.txd_out, 32'h555555FB);
    reset = 1'b1;
    @(negedge txclk_2x);
    check("mr.txd",  bus.txd_out,  32'h07070707);
    check("mr.txc",  bus.txc_out,  4'hF);
    check("mr.mode", bus.tx_mode,  M_IDLE);
    check("mr.drop", bus.drop_cnt, '0);
    check("mr.ack",  bus.tx_ack,   1'b1);
    reset    = 1'b0;
    exp_drop = 0;
    // in_frame was cleared by reset, so the fault applies immediately.
    do_word("mr.rf", 64'h77777777_77777777, 8'h00, 2'b01, M_RF);

    // Saturation of the drop counter: 2^DW + 3 remote-fault words.
    for (int i = 0; i < (1 << DW) + 3; i++)
      do_word("sat", 64'h12345678_9ABCDEF0, 8'h00, 2'b10, M_IDLE);
    check("sat.final", bus.drop_cnt, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_rs_layer.md
TX_RS_LAYER -- requirements
Module: tx_rs_layer

Interface
REQ-001 Parameter: DROP_CNT_W, default 16, width of the dropped-word counter.
REQ-002 txclk_2x  in  1  sole clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 txd64  in  64  MAC data word; lane n = bits 8n+7:8n, lane 0 first on the wire.
REQ-005 txc8  in  8  control flag per lane; bit n set means lane n is a control character.
REQ-006 tx_ack  out  1  high in the cycle where txd64/txc8 are sampled at the closing edge.
REQ-007 link_fault  in  2  00 OK, 01 local fault, 10 remote fault, 11 treated as 01.
REQ-008 txd_out  out  32  XGMII-side column; lane 0 = bits 7:0.
REQ-009 txc_out  out  4  XGMII-side control flags.
REQ-010 tx_mode  out  2  mode of the last sampled word: 00 pass, 01 sending RF, 10 sending idle.
REQ-011 drop_cnt  out  DROP_CNT_W  count of MAC words discarded during fault modes.

Function
REQ-012 A phase bit shall toggle every cycle; tx_ack = (phase == 0), giving one 64-bit word every two cycles.
REQ-013 At each sampling edge the effective mode shall come from link_fault and registered in_frame:
- in_frame=1: pass.
- otherwise 00: pass; 01/11: RF; 10: idle.
REQ-014 Pass: the word is forwarded unchanged.
REQ-015 RF: the word is replaced by RF columns (txd 32'h0200009C, txc 4'b0001) in both halves.
REQ-016 Idle: the word is replaced by idle columns (txd 32'h07070707, txc 4'hF) in both halves.
REQ-017 Latency: the low half (lanes 0-3) shall drive txd_out/txc_out in the cycle after the sampling edge, and the high half (lanes 4-7) in the following cycle.
REQ-018 Outputs shall be registered.
REQ-019 in_frame shall update only from forwarded words, scanning lanes 0 to 7 in order:
- control 0xFB (Start) sets it;
- control 0xFD (Terminate) clears it;
- the last event in the word wins.
REQ-020 A fault raised mid-frame shall leave the frame intact; the switch to RF/idle shall happen at the first word after the word containing Terminate.
REQ-021 A fault clearing shall return to pass at the next sampling edge; no partial frame shall ever be emitted from a discarded word.
REQ-022 drop_cnt shall increment by 1 per word sampled in RF or idle mode and saturate at all-ones.
REQ-023 tx_mode shall update at the sampling edge.

Reset
REQ-024 While reset is high, each of the following shall take its reset value at each clock edge:
- phase = 0, in_frame = 0;
- txd_out = 32'h07070707, txc_out = 4'hF;
- tx_mode = 10, drop_cnt = 0.
REQ-025 The first tx_ack shall occur in the first cycle after reset is deasserted.
REQ-026 Reset asserted mid-frame shall abandon the frame, with no Terminate generated.

Configuration
REQ-027 Macro TX_RS_FRAME_GUARD_EN:
- Defined: REQ-013/REQ-020 frame protection applies.
- Undefined: the effective mode ignores in_frame, so a fault takes effect at the next sampling edge, possibly truncating a frame; a replaced word clears in_frame.

Verification
REQ-028 Reset, link_fault=00 -> txd_out=32'h07070707, txc_out=4'hF, drop_cnt=0, tx_ack high in the first post-reset cycle.
REQ-029 link_fault=00, word txd64=64'h0706050403020100, txc8=8'h00 -> txd_out=32'h03020100 in the next cycle, then 32'h07060504.
REQ-030 link_fault=01 with idle MAC input for 4 words -> 8 columns of 32'h0200009C/4'b0001, drop_cnt=4, tx_mode=01.
REQ-031 Start word sent, link_fault=10 raised before Terminate (guard on) -> remaining frame words forwarded through Terminate, then idle columns; with the guard macro undefined -> idle from the next word.
REQ-032 link_fault=10 for 2^DROP_CNT_W+3 words (DROP_CNT_W=4) -> drop_cnt holds 4'hF.
REQ-033 Reset asserted in phase 1 mid-frame -> idle outputs next cycle; in_frame=0; following word with link_fault=01 -> RF.
